// File: rtl/tnoc_packet_arbiter.sv
// -----------------------------------------------------------------------------
// tnoc_packet_arbiter
//
// Packet-level round-robin arbiter that shares one flit output port among
// ENTRIES requesters. A requester wins on a head flit and keeps the grant
// until its tail flit is accepted, so wormhole packets never interleave.
//
// Optional watchdog: define TNOC_PACKET_ARBITER_WATCHDOG_EN to add the
// stall_error port and a 16-bit stall counter with threshold STALL_LIMIT.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   flit_valid   per-requester flit valid
//   flit_head    per-requester head-flit marker (qualified by flit_valid)
//   flit_tail    per-requester tail-flit marker (qualified by flit_valid)
//   flit_ready   output port ready
//   grant        registered one-hot grant, zero when idle
//   grant_index  registered binary index of the grant, zero when idle
//   locked       a packet currently owns the output
//   flit_accept  a flit transfers this cycle
//   stall_error  sticky watchdog flag (watchdog build only)
// -----------------------------------------------------------------------------
module tnoc_packet_arbiter #(
  parameter int unsigned ENTRIES     = 5,
  parameter int unsigned STALL_LIMIT = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ENTRIES-1:0]         flit_valid,
  input  logic [ENTRIES-1:0]         flit_head,
  input  logic [ENTRIES-1:0]         flit_tail,
  input  logic                       flit_ready,
  output logic [ENTRIES-1:0]         grant,
  output logic [$clog2(ENTRIES)-1:0] grant_index,
  output logic                       locked,
  output logic                       flit_accept
`ifdef TNOC_PACKET_ARBITER_WATCHDOG_EN
  ,
  output logic                       stall_error
`endif
);

  localparam int unsigned IdxW = $clog2(ENTRIES);
  // One extra bit so pointer + offset never wraps before the modulo fix-up.
  localparam int unsigned SumW = IdxW + 1;

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e             state_q, state_d;
  logic [ENTRIES-1:0] grant_q, grant_d;
  logic [IdxW-1:0]    index_q, index_d;
  logic [IdxW-1:0]    ptr_q, ptr_d;

  logic [ENTRIES-1:0] eligible;
  logic               release_now;
  logic               win_found;
  logic [IdxW-1:0]    win_idx;
  logic [IdxW-1:0]    win_next;
  logic [SumW-1:0]    cand;

  assign grant       = grant_q;
  assign grant_index = index_q;
  assign locked      = (state_q == StLocked);
  assign flit_accept = (|(grant_q & flit_valid)) & flit_ready;

  // Tail of the owning packet leaves the port this cycle.
  assign release_now = locked & flit_accept & flit_tail[index_q];

  // The releasing requester sits out the re-arbitration in its release cycle.
  always_comb begin
    eligible = flit_valid & flit_head;
    if (release_now) begin
      eligible = eligible & ~grant_q;
    end
  end

  // Round-robin scan starting at the pointer, wrapping modulo ENTRIES.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < ENTRIES; k++) begin
      cand = {1'b0, ptr_q} + SumW'(k);
      if (cand >= SumW'(ENTRIES)) begin
        cand = cand - SumW'(ENTRIES);
      end
      if (!win_found && eligible[cand[IdxW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IdxW-1:0];
      end
    end
  end

  assign win_next = (win_idx == IdxW'(ENTRIES - 1)) ? '0 : win_idx + IdxW'(1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    index_d = index_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StLocked;
          grant_d = {{(ENTRIES-1){1'b0}}, 1'b1} << win_idx;
          index_d = win_idx;
          ptr_d   = win_next;
        end
      end
      StLocked: begin
        if (release_now) begin
          if (win_found) begin
            // Back-to-back hand-over, no idle bubble.
            grant_d = {{(ENTRIES-1){1'b0}}, 1'b1} << win_idx;
            index_d = win_idx;
            ptr_d   = win_next;
          end else begin
            state_d = StIdle;
            grant_d = '0;
            index_d = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        index_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      index_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      index_q <= index_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef TNOC_PACKET_ARBITER_WATCHDOG_EN
  localparam logic [15:0] StallLimit = 16'(STALL_LIMIT);

  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        stall_err_q, stall_err_d;

  // Release always coincides with an accept, so it is covered by the clear.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!locked || flit_accept) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != StallLimit) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    stall_err_d = stall_err_q | (stall_cnt_q == StallLimit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign stall_error = stall_err_q;
`endif

endmodule

// File: tb/tb_tnoc_packet_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tnoc_packet_arbiter
//
// Directed self-checking bench for tnoc_packet_arbiter with ENTRIES=4 and
// STALL_LIMIT=8. Inputs change 1 time unit after the rising edge; outputs are
// checked 5 time units after the rising edge.
// -----------------------------------------------------------------------------
module tb_tnoc_packet_arbiter;

  localparam int unsigned N = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] flit_valid;
  logic [N-1:0] flit_head;
  logic [N-1:0] flit_tail;
  logic         flit_ready;
  logic [N-1:0] grant;
  logic [1:0]   grant_index;
  logic         locked;
  logic         flit_accept;
`ifdef TNOC_PACKET_ARBITER_WATCHDOG_EN
  logic         stall_error;
`endif

  int n_cmp = 0;
  int n_err = 0;

  tnoc_packet_arbiter #(
    .ENTRIES     (N),
    .STALL_LIMIT (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flit_valid  (flit_valid),
    .flit_head   (flit_head),
    .flit_tail   (flit_tail),
    .flit_ready  (flit_ready),
    .grant       (grant),
    .grant_index (grant_index),
    .locked      (locked),
    .flit_accept (flit_accept)
`ifdef TNOC_PACKET_ARBITER_WATCHDOG_EN
    ,
    .stall_error (stall_error)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, then settle to mid-cycle.
  task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] h,
                     input logic [N-1:0] t, input logic r);
    @(posedge clk);
    #1;
    flit_valid = v;
    flit_head  = h;
    flit_tail  = t;
    flit_ready = r;
    #4;
  endtask

  task automatic do_reset();
    flit_valid = '0;
    flit_head  = '0;
    flit_tail  = '0;
    flit_ready = 1'b1;
    rst_n      = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int         pos [N];
  logic [N-1:0] hv;
  logic [N-1:0] tv;
  int         g;

  initial begin
    rst_n      = 1'b1;
    flit_valid = '0;
    flit_head  = '0;
    flit_tail  = '0;
    flit_ready = 1'b1;
    #2;

    // ---------------- Reset state
    do_reset();
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_index", 32'(grant_index), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_accept", 32'(flit_accept), 32'h0);

    // ---------------- Single-flit packets on 1 and 3, back-to-back
    cyc(4'b1010, 4'b1010, 4'b1010, 1'b1);
    chk("sf_c0_grant", 32'(grant), 32'h0);
    chk("sf_c0_accept", 32'(flit_accept), 32'h0);
    cyc(4'b1010, 4'b1010, 4'b1010, 1'b1);
    chk("sf_c1_grant", 32'(grant), 32'h2);
    chk("sf_c1_index", 32'(grant_index), 32'h1);
    chk("sf_c1_accept", 32'(flit_accept), 32'h1);
    cyc(4'b1000, 4'b1000, 4'b1000, 1'b1);
    chk("sf_c2_grant", 32'(grant), 32'h8);
    chk("sf_c2_index", 32'(grant_index), 32'h3);
    chk("sf_c2_accept", 32'(flit_accept), 32'h1);
    cyc(4'b0000, 4'b0000, 4'b0000, 1'b1);
    chk("sf_c3_grant", 32'(grant), 32'h0);
    chk("sf_c3_locked", 32'(locked), 32'h0);
    // Pointer is back at 0: all-request picks requester 0.
    cyc(4'b1111, 4'b1111, 4'b1111, 1'b1);
    cyc(4'b0000, 4'b0000, 4'b0000, 1'b1);
    chk("sf_ptr0_grant", 32'(grant), 32'h1);

    // ---------------- Saturated 3-flit packets on all requesters
    do_reset();
    for (int i = 0; i < N; i++) pos[i] = 0;
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < N; i++) begin
        hv[i] = (pos[i] == 0);
        tv[i] = (pos[i] == 2);
      end
      cyc(4'b1111, hv, tv, 1'b1);
      if (c == 0) begin
        chk("rr_c0_grant", 32'(grant), 32'h0);
      end else begin
        g = ((c - 1) / 3) % N;
        chk($sformatf("rr_c%0d_grant", c), 32'(grant), 32'(1) << g);
        chk($sformatf("rr_c%0d_index", c), 32'(grant_index), 32'(g));
        chk($sformatf("rr_c%0d_locked", c), 32'(locked), 32'h1);
        pos[g] = (pos[g] + 1) % 3;
      end
    end

    // ---------------- Backpressure mid-packet, head on 0 meanwhile
    do_reset();
    cyc(4'b0100, 4'b0100, 4'b0000, 1'b1);
    cyc(4'b0100, 4'b0100, 4'b0000, 1'b1);
    chk("bp_c1_grant", 32'(grant), 32'h4);
    chk("bp_c1_accept", 32'(flit_accept), 32'h1);
    cyc(4'b0100, 4'b0000, 4'b0000, 1'b1);
    chk("bp_c2_accept", 32'(flit_accept), 32'h1);
    for (int c = 3; c < 8; c++) begin
      cyc(4'b0101, 4'b0001, 4'b0000, 1'b0);
      chk($sformatf("bp_c%0d_grant", c), 32'(grant), 32'h4);
      chk($sformatf("bp_c%0d_accept", c), 32'(flit_accept), 32'h0);
    end
    cyc(4'b0101, 4'b0001, 4'b0000, 1'b1);
    chk("bp_c8_grant", 32'(grant), 32'h4);
    chk("bp_c8_accept", 32'(flit_accept), 32'h1);
    cyc(4'b0101, 4'b0001, 4'b0100, 1'b1);
    chk("bp_c9_grant", 32'(grant), 32'h4);
    chk("bp_c9_accept", 32'(flit_accept), 32'h1);
    cyc(4'b0001, 4'b0001, 4'b0000, 1'b1);
    chk("bp_c10_grant", 32'(grant), 32'h1);
    chk("bp_c10_locked", 32'(locked), 32'h1);

    // ---------------- Self re-request after release gives one idle cycle
    do_reset();
    cyc(4'b0001, 4'b0001, 4'b0000, 1'b1);
    cyc(4'b0001, 4'b0001, 4'b0000, 1'b1);
    chk("rq_c1_grant", 32'(grant), 32'h1);
    cyc(4'b0001, 4'b0000, 4'b0001, 1'b1);
    chk("rq_c2_accept", 32'(flit_accept), 32'h1);
    cyc(4'b0001, 4'b0001, 4'b0001, 1'b1);
    chk("rq_c3_grant", 32'(grant), 32'h0);
    chk("rq_c3_locked", 32'(locked), 32'h0);
    chk("rq_c3_accept", 32'(flit_accept), 32'h0);
    cyc(4'b0000, 4'b0000, 4'b0000, 1'b1);
    chk("rq_c4_grant", 32'(grant), 32'h1);

    // ---------------- Protocol violation: body flit while idle is ignored
    do_reset();
    cyc(4'b0010, 4'b0000, 4'b0010, 1'b1);
    cyc(4'b0000, 4'b0000, 4'b0000, 1'b1);
    chk("pv_grant", 32'(grant), 32'h0);
    chk("pv_locked", 32'(locked), 32'h0);

    // ---------------- Asynchronous reset mid-packet
    do_reset();
    cyc(4'b0100, 4'b0100, 4'b0000, 1'b1);
    cyc(4'b0100, 4'b0100, 4'b0000, 1'b1);
    chk("ar_pre_grant", 32'(grant), 32'h4);
    cyc(4'b0100, 4'b0000, 4'b0000, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("ar_grant", 32'(grant), 32'h0);
    chk("ar_locked", 32'(locked), 32'h0);
    chk("ar_index", 32'(grant_index), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Pointer 0 ordering: 2 beats 3 (a stale pointer of 3 would pick 3).
    cyc(4'b1100, 4'b1100, 4'b1100, 1'b1);
    cyc(4'b0000, 4'b0000, 4'b0000, 1'b1);
    chk("ar_new_grant", 32'(grant), 32'h4);

`ifdef TNOC_PACKET_ARBITER_WATCHDOG_EN
    // ---------------- Watchdog: 10 stall cycles with STALL_LIMIT=8
    do_reset();
    cyc(4'b0010, 4'b0010, 4'b0000, 1'b1);
    cyc(4'b0010, 4'b0010, 4'b0000, 1'b1);
    chk("wd_c1_grant", 32'(grant), 32'h2);
    for (int c = 2; c < 12; c++) begin
      cyc(4'b0000, 4'b0000, 4'b0000, 1'b1);
      chk($sformatf("wd_c%0d_err", c), 32'(stall_error), (c >= 11) ? 32'h1 : 32'h0);
    end
    cyc(4'b0010, 4'b0000, 4'b0010, 1'b1);
    chk("wd_resume_accept", 32'(flit_accept), 32'h1);
    cyc(4'b0000, 4'b0000, 4'b0000, 1'b1);
    chk("wd_sticky", 32'(stall_error), 32'h1);
    chk("wd_idle_grant", 32'(grant), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tnoc_packet_arbiter.md
Name: tnoc_packet_arbiter

Overview:
- Packet-level round-robin arbiter that shares one flit output port among ENTRIES requesting input ports. It sits in front of the router output mux.
- It picks a requester on a head flit and holds the grant until that requester's tail flit is accepted. Wormhole packets are therefore never interleaved.
- It drives one-hot and binary grant selects for the downstream flit mux. An optional watchdog flags a grant that stalls too long.

Parameters:
- ENTRIES, 5, number of requesters; legal range 2..16.
- STALL_LIMIT, 1024, stall-cycle threshold for the watchdog; legal range 2..65535. Used only when the watchdog is compiled in.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- flit_valid  input  ENTRIES  per-requester flit valid.
- flit_head  input  ENTRIES  flit on requester i is a head flit; qualified by flit_valid[i].
- flit_tail  input  ENTRIES  flit on requester i is a tail flit; qualified by flit_valid[i]. Single-flit packets have head=tail=1.
- flit_ready  input  1  output port ready.
- grant  output  ENTRIES  one-hot grant; all zero when idle.
- grant_index  output  $clog2(ENTRIES)  binary index of the granted requester; 0 when idle.
- locked  output  1  a packet currently owns the output.
- flit_accept  output  1  a flit transfers this cycle. Defined as |(grant & flit_valid) & flit_ready.
- stall_error  output  1  watchdog flag; present only with the macro.

Behaviour:
- Reset: state IDLE; grant='0, grant_index=0, locked=0; priority pointer=0; stall counter=0; stall_error=0. Reset is asynchronous and may occur mid-packet: the lock is dropped immediately and the pointer returns to 0.
- Eligibility: while IDLE, requester i is eligible iff flit_valid[i] & flit_head[i].
  - A valid non-head flit on an ungranted requester is a protocol violation. It is never granted and never accepted.
- Selection: scan from the pointer upward, modulo ENTRIES. The first eligible requester wins.
- All grant outputs are registered. Latency is 1 cycle: a request in IDLE at cycle t produces grant at t+1.
- On a new grant to index g, the pointer becomes (g+1) mod ENTRIES.
- State IDLE: if any requester is eligible, register the grant and go to LOCKED. Otherwise stay in IDLE.
- State LOCKED:
  - grant is held stable. flit_valid and flit_head on other requesters are ignored.
  - Release occurs when flit_accept & flit_tail[grant_index].
  - In the release cycle, re-arbitrate among eligible requesters with the releasing requester masked out.
    - If a winner exists, grant it in the next cycle and stay in LOCKED (back-to-back, no idle bubble).
    - Otherwise go to IDLE with grant='0.
  - The masked requester rejoins arbitration in the following cycle.
- Hold rules:
  - flit_ready low: no transfer; grant held.
  - flit_valid low on the granted requester while locked: grant held indefinitely; no preemption.
- Single-flit packet: the grant lasts exactly one accept cycle, then release.
- No starvation: with all requesters saturated, each is granted once in every ENTRIES consecutive packets.

Optional Feature:
- Macro: TNOC_PACKET_ARBITER_WATCHDOG_EN.
- Defined:
  - A 16-bit stall counter increments each cycle that locked=1 and flit_accept=0.
  - The counter clears on any flit_accept, on release, or while IDLE, and saturates at STALL_LIMIT.
  - When the counter reaches STALL_LIMIT, stall_error is set one cycle later. It is sticky until rst_n.
  - The watchdog does not alter arbitration.
- Undefined: the stall_error port and counter are absent; behaviour is otherwise identical.

Test Plan:
- ENTRIES=4, reset, then single-flit head+tail requests on requesters 1 and 3 at cycle 0 -> grant=0010 at cycle 1 and accepted. At cycle 2, grant=1000 with no idle cycle between. Pointer ends at 0.
- All 4 requesters send continuous 3-flit packets, flit_ready=1 -> grant order 0,1,2,3,0,… Each grant lasts exactly 3 cycles. locked stays 1 throughout.
- Requester 2 granted on a 4-flit packet, flit_ready low for 5 cycles mid-packet, head flit on requester 0 meanwhile -> grant stays 0100 until 2's tail is accepted. Then grant=0001.
- Requester 0 releases (tail accepted) while its next head flit is already valid and no other requester is valid -> IDLE for 1 cycle (grant=0000). Then grant=0001.
- Assert rst_n low mid-packet while grant=0100 -> grant=0000, locked=0 immediately. After release, a new request from 2 is granted via pointer 0 ordering.
- Watchdog build, STALL_LIMIT=8: granted requester holds flit_valid=0 for 10 cycles -> stall_error=1 after the 8th stall cycle, sticky after the traffic resumes.
